signed_sat_accumulator: RTL and testbench
=========================================

// Module: signed_sat_accumulator
// PURPOSE
//  Multi-channel signed accumulator with optional saturation. Each accepted
//  sample is added to the running sum of its channel; the result is clamped to
//  the signed WIDTH range and returned on a valid/ready output stream.
//  Sits between a sample source and any consumer needing per-channel running
//  sums with overflow tracking. Two-stage pipeline with full backpressure.
// PARAMETERS
//  WIDTH     8  data and accumulator width, two's complement
//  N_CH      4  number of channels (>=2); CH_W = $clog2(N_CH) is derived
//  SATURATE  1  1: clamp to MAX/MIN on overflow; 0: wrap modulo 2^WIDTH
// PORTS
//  clk         in   1          clock, all logic on posedge
//  rst_n       in   1          asynchronous reset, active-low
//  in_valid    in   1          input sample valid
//  in_ready    out  1          block can accept a sample this cycle
//  in_ch       in   CH_W       channel index of the sample
//  in_data     in   WIDTH      signed sample
//  in_clear    in   1          load: acc[ch] := in_data, no add
//  out_valid   out  1          result valid
//  out_ready   in   1          consumer accepts the result
//  out_ch      out  CH_W       channel of the result
//  out_sum     out  WIDTH      new acc[ch] value, signed
//  out_sat     out  1          this result was clamped (always 0 if SATURATE=0)
//  sat_sticky  out  N_CH       per-channel "overflow seen since clear" flag
//  sticky_clr  in   1          clear all sat_sticky bits
// BEHAVIOUR
//  - Reset (rst_n=0, async): stage-1 valid, out_valid, out_ch, out_sum, out_sat,
//    every acc[i] and sat_sticky all go to 0. in_ready = 1 after reset.
//    Reset mid-operation drops in-flight samples; nothing is replayed.
//  - Stage 1: a sample is accepted when in_valid && in_ready and is registered
//    with ch/data/clear.
//  - Advance: adv = v1 && (!out_valid || out_ready). On adv, compute
//    res = acc[ch1] + data1 and write acc[ch1] and the output registers in the
//    same edge.
//  - in_ready = !v1 || adv. No combinational path from in_valid to in_ready.
//  - Latency: 2 cycles from acceptance to out_valid when unstalled.
//    Throughput: 1 sample per cycle.
//  - Same-channel back-to-back samples need no forwarding: acc is read and
//    written only on adv.
//  - Arithmetic: add in WIDTH+1 bits, sign-extended.
//    - SATURATE=1: res > 2^(W-1)-1 gives MAX and out_sat=1; res < -2^(W-1)
//      gives MIN and out_sat=1. Otherwise the exact value with out_sat=0.
//    - Overflow is possible only when both operands have the same sign.
//    - SATURATE=0: low WIDTH bits, out_sat=0, but sat_sticky still flags
//      the overflow.
//  - in_clear: acc[ch1] := data1, out_sum = data1, out_sat = 0, no overflow.
//  - Output hold: while out_valid && !out_ready, out_* are held stable. Stage 1
//    holds a second sample; after that in_ready=0.
//  - out_valid drops after a handshake if no new adv occurs that cycle.
//  - sat_sticky[ch1] is set on adv when overflow occurs. sticky_clr clears all
//    bits. If a set and sticky_clr happen in the same cycle, the set wins for
//    that channel.
//  - in_ch >= N_CH (non-power-of-2 N_CH) is an illegal input; the bench
//    asserts it never happens.
// STRUCTURE
//  - Package sat_acc_pkg: state no typedef; holds a function returning
//    MAX/MIN for a given width.
//  - Sub-module signed_sat_add #(WIDTH, SATURATE): combinational a+b producing
//    sum and ovf, instantiated once in the advance path.
//  - Top level: stage-1 register, acc array (N_CH x WIDTH flops), output
//    registers, sticky register, handshake logic.
// TESTING (WIDTH=8, N_CH=4, out_ready=1 unless stated)
//  1. ch0 clear 100, then +50 -> out_sum 100 (sat 0), then 127 (sat 1);
//     sat_sticky=0001.
//  2. ch1 clear -100, then -50 -> -128, out_sat=1; then +27 -> -101, sat 0.
//  3. ch2 from reset, +1 on 3 consecutive cycles -> out_sum 1,2,3 on 3
//     consecutive cycles, first one 2 cycles after the first accept.
//  4. out_ready=0 for 4 cycles while 4 samples are offered -> 2 accepted,
//     in_ready=0 after that; release gives in-order results, no loss or dup.
//  5. sticky_clr in the same cycle ch3 overflows -> sat_sticky[3] stays 1;
//     sticky_clr alone next cycle -> 0.
//  6. SATURATE=0: 100+50 -> -106, out_sat=0, sticky set. Assert rst_n
//     mid-stall -> out_valid=0, acc=0 immediately.

Source files
------------

// File: rtl/sat_acc_pkg.sv
// Shared helpers for the signed saturating accumulator.
// Provides the clamp limits for a given data width.
package sat_acc_pkg;

    // Low `width` bits hold MAX (neg=0) or MIN (neg=1) in two's complement
    function automatic logic [31:0] sat_limit(
        input int   width,
        input logic neg
    );
        logic [31:0] top;
        top = 32'd1 << (width - 1);
        return neg ? top : top - 32'd1;
    endfunction

endpackage

// File: rtl/signed_sat_add.sv
// Combinational signed add with overflow detect.
// Optionally clamps the result to the signed range.
module signed_sat_add
    import sat_acc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             sat
);

    localparam logic [31:0] MAX_L = sat_limit(WIDTH, 1'b0);
    localparam logic [31:0] MIN_L = sat_limit(WIDTH, 1'b1);

    logic [WIDTH:0] full;

    assign full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign ovf  = full[WIDTH] != full[WIDTH-1];

    // Clamp toward the sign of the true sum when enabled
    always_comb begin
        sum = full[WIDTH-1:0];
        sat = 1'b0;
        if (SATURATE && ovf) begin
            sat = 1'b1;
            sum = full[WIDTH] ? MIN_L[WIDTH-1:0]
                              : MAX_L[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Per-channel signed running-sum pipeline.
// Two stages, valid/ready on both sides, sticky overflow flags.
module signed_sat_accumulator
    import sat_acc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_CH     = 4,
    parameter bit SATURATE = 1'b1,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_sat,
    output logic [N_CH-1:0]  sat_sticky,
    input  logic             sticky_clr
);

    logic             v1;
    logic [CH_W-1:0]  ch1;
    logic [WIDTH-1:0] data1;
    logic             clr1;
    logic             adv;

    logic [WIDTH-1:0] acc [N_CH];

    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic             add_sat;
    logic [WIDTH-1:0] res;
    logic             res_sat;
    logic             res_ovf;
    logic [N_CH-1:0]  sticky_nxt;

    // acc is only touched on adv, so back-to-back hits need no bypass
    assign adv      = v1 && (!out_valid || out_ready);
    assign in_ready = !v1 || adv;

    signed_sat_add #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_add (
        .a   (acc[ch1]),
        .b   (data1),
        .sum (add_sum),
        .ovf (add_ovf),
        .sat (add_sat)
    );

    // A clear loads the sample verbatim and can never overflow
    always_comb begin
        res     = clr1 ? data1 : add_sum;
        res_sat = !clr1 && add_sat;
        res_ovf = !clr1 && add_ovf;
    end

    // Stage 1: capture an accepted sample until it advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            ch1   <= '0;
            data1 <= '0;
            clr1  <= 1'b0;
        end else if (in_valid && in_ready) begin
            v1    <= 1'b1;
            ch1   <= in_ch;
            data1 <= in_data;
            clr1  <= in_clear;
        end else if (adv) begin
            v1    <= 1'b0;
        end
    end

    // Per-channel accumulators, written with the result on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                acc[i] <= '0;
            end
        end else if (adv) begin
            acc[ch1] <= res;
        end
    end

    // Output registers hold while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= 1'b1;
            out_ch    <= ch1;
            out_sum   <= res;
            out_sat   <= res_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A fresh overflow beats a simultaneous global clear
    always_comb begin
        sticky_nxt = sticky_clr ? '0 : sat_sticky;
        if (adv && res_ovf) begin
            sticky_nxt[ch1] = 1'b1;
        end
    end

    // Sticky overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_sticky <= '0;
        end else begin
            sat_sticky <= sticky_nxt;
        end
    end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Scoreboard bench for signed_sat_accumulator.
// Two instances: saturating and wrapping.
module tb_signed_sat_accumulator;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] sum;
        logic       sat;
        bit         lat;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_ch;
    logic [7:0] in_data;
    logic       in_clear;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_ch;
    logic [7:0] out_sum;
    logic       out_sat;
    logic [3:0] sat_sticky;
    logic       sticky_clr;

    logic       rst_n_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic [1:0] in_ch_b;
    logic [7:0] in_data_b;
    logic       in_clear_b;
    logic       out_valid_b;
    logic       out_ready_b;
    logic [1:0] out_ch_b;
    logic [7:0] out_sum_b;
    logic       out_sat_b;
    logic [3:0] sat_sticky_b;
    logic       sticky_clr_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    signed_sat_accumulator #(
        .WIDTH(8), .N_CH(4), .SATURATE(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_data(in_data),
        .in_clear(in_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_sum(out_sum),
        .out_sat(out_sat), .sat_sticky(sat_sticky),
        .sticky_clr(sticky_clr)
    );

    signed_sat_accumulator #(
        .WIDTH(8), .N_CH(4), .SATURATE(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_ch(in_ch_b), .in_data(in_data_b),
        .in_clear(in_clear_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_ch(out_ch_b), .out_sum(out_sum_b),
        .out_sat(out_sat_b), .sat_sticky(sat_sticky_b),
        .sticky_clr(sticky_clr_b)
    );

    always @(posedge clk) begin
        if (in_valid)
            assert (int'(in_ch) < 4) else $error("illegal in_ch");
        if (in_valid_b)
            assert (int'(in_ch_b) < 4) else $error("illegal in_ch_b");
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Monitor A
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected: ch %0d sum %0d",
                         out_ch, $signed(out_sum));
            end else begin
                ea = qa.pop_front();
                if (out_ch !== ea.ch || out_sum !== ea.sum ||
                    out_sat !== ea.sat) begin
                    errors++;
                    $display("FAIL a_result: got ch%0d %0d sat%0b expected ch%0d %0d sat%0b",
                             out_ch, $signed(out_sum), out_sat,
                             ea.ch, $signed(ea.sum), ea.sat);
                end
                if (ea.lat) begin
                    checks++;
                    if (cyc != ea.cyc + 2) begin
                        errors++;
                        $display("FAIL a_latency: got %0d expected %0d",
                                 cyc - ea.cyc, 2);
                    end
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst_n_b && out_valid_b && out_ready_b) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: ch %0d sum %0d",
                         out_ch_b, $signed(out_sum_b));
            end else begin
                eb = qb.pop_front();
                if (out_ch_b !== eb.ch || out_sum_b !== eb.sum ||
                    out_sat_b !== eb.sat) begin
                    errors++;
                    $display("FAIL b_result: got ch%0d %0d sat%0b expected ch%0d %0d sat%0b",
                             out_ch_b, $signed(out_sum_b), out_sat_b,
                             eb.ch, $signed(eb.sum), eb.sat);
                end
            end
        end
    end

    task automatic send(input bit b,
                        input logic [1:0] ch,
                        input logic [7:0] d,
                        input logic clr,
                        input logic [7:0] es,
                        input logic esat,
                        input bit lat);
        int   n;
        exp_t e;
        if (b) begin
            in_valid_b = 1'b1; in_ch_b = ch;
            in_data_b = d; in_clear_b = clr;
        end else begin
            in_valid = 1'b1; in_ch = ch;
            in_data = d; in_clear = clr;
        end
        n = 0;
        @(negedge clk);
        while ((b ? in_ready_b : in_ready) !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got stalled %0d expected accept", n);
        end else begin
            e.ch = ch; e.sum = es; e.sat = esat;
            e.lat = lat; e.cyc = cyc;
            if (b) qb.push_back(e);
            else   qa.push_back(e);
        end
        @(posedge clk);
        #1;
        if (b) in_valid_b = 1'b0;
        else   in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0",
                     qa.size(), qb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0;
        in_valid = 0; in_ch = 0; in_data = 0; in_clear = 0;
        in_valid_b = 0; in_ch_b = 0; in_data_b = 0; in_clear_b = 0;
        out_ready = 1; out_ready_b = 1;
        sticky_clr = 0; sticky_clr_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_sticky", 32'(sat_sticky), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        rst_n = 1'b1; rst_n_b = 1'b1;
        @(posedge clk);
        #1;

        // ch0 clear then positive saturation
        send(0, 2'd0, 8'd100, 1, 8'd100, 0, 0);
        send(0, 2'd0, 8'd50, 0, 8'd127, 1, 0);
        drain();
        chk("sticky_t1", 32'(sat_sticky), 32'b0001);

        // ch1 negative saturation then recover
        send(0, 2'd1, -8'sd100, 1, -8'sd100, 0, 0);
        send(0, 2'd1, -8'sd50, 0, -8'sd128, 1, 0);
        send(0, 2'd1, 8'd27, 0, -8'sd101, 0, 0);
        drain();
        chk("sticky_t2", 32'(sat_sticky), 32'b0011);

        // ch2 back-to-back, latency 2
        send(0, 2'd2, 8'd1, 0, 8'd1, 0, 1);
        send(0, 2'd2, 8'd1, 0, 8'd2, 0, 1);
        send(0, 2'd2, 8'd1, 0, 8'd3, 0, 1);
        drain();

        // backpressure: two slots fill, then in_ready drops
        out_ready = 1'b0;
        fork
            begin
                send(0, 2'd2, 8'd1, 0, 8'd4, 0, 0);
                send(0, 2'd2, 8'd2, 0, 8'd6, 0, 0);
                send(0, 2'd2, 8'd3, 0, 8'd9, 0, 0);
                send(0, 2'd2, 8'd4, 0, 8'd13, 0, 0);
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_ready_c3", 32'(in_ready), 0);
                chk("stall_sum_c3", 32'(out_sum), 4);
                @(negedge clk);
                chk("stall_ready_c4", 32'(in_ready), 0);
                chk("stall_valid_c4", 32'(out_valid), 1);
                chk("stall_sum_c4", 32'(out_sum), 4);
                chk("stall_accepted", 32'(qa.size()), 2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // sticky set wins over a same-cycle clear
        send(0, 2'd3, 8'd120, 1, 8'd120, 0, 0);
        send(0, 2'd3, 8'd20, 0, 8'd127, 1, 0);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("sticky_set_wins", 32'(sat_sticky), 32'b1000);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("sticky_cleared", 32'(sat_sticky), 0);
        drain();

        // wrapping instance
        send(1, 2'd0, 8'd100, 1, 8'd100, 0, 0);
        send(1, 2'd0, 8'd50, 0, -8'sd106, 0, 0);
        drain();
        chk("b_sticky_wrap", 32'(sat_sticky_b), 32'b0001);

        // reset in the middle of a stall
        out_ready_b = 1'b0;
        send(1, 2'd1, 8'd5, 0, 8'd5, 0, 0);
        send(1, 2'd1, 8'd6, 0, 8'd11, 0, 0);
        @(posedge clk);
        #1;
        chk("b_stalled_valid", 32'(out_valid_b), 1);
        rst_n_b = 1'b0;
        #1;
        chk("b_rst_valid", 32'(out_valid_b), 0);
        chk("b_rst_sum", 32'(out_sum_b), 0);
        chk("b_rst_sticky", 32'(sat_sticky_b), 0);
        chk("b_rst_ready", 32'(in_ready_b), 1);
        qb.delete();
        @(posedge clk);
        #1;
        rst_n_b = 1'b1;
        out_ready_b = 1'b1;
        send(1, 2'd0, 8'd7, 0, 8'd7, 0, 0);
        send(1, 2'd1, 8'd3, 0, 8'd3, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
